acc_bias_accum: RTL and testbench
=================================

# acc_bias_accum

Accumulates partial-sum tiles from the PE array across the K dimension, adds a per-column bias, and presents the finished COLS×COLS accumulator grid to the bound/ReLU stage as `o_acc_bias`. It sits directly upstream of the bound/ReLU stage and matches that stage's `AB_BW`-per-element packing. A single ready/valid handshake on the output holds the result until the consumer accepts it.

## Interface
- `COLS`, 5, grid dimension; the grid has COLS×COLS elements.
- `PSUM_BW`, 20, signed width of each incoming partial sum.
- `BIAS_BW`, 16, signed width of each bias value.
- `AB_BW`, 25, signed width of each accumulator/output element.
- `CNT_BW`, 8, width of the tile-count input.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  starts a job; accepted only in IDLE.
- `i_num_tiles`  in  CNT_BW  number of psum tiles in the job; sampled with `i_start`.
- `i_bias`  in  BIAS_BW*COLS  bias per column c at `[(c+1)*BIAS_BW-1 -: BIAS_BW]`; sampled with `i_start`.
- `i_psum_valid`  in  1  `i_psum` carries one tile this cycle.
- `i_psum`  in  PSUM_BW*COLS*COLS  element (r,c) at index k=r*COLS+c, bits `[(k+1)*PSUM_BW-1 -: PSUM_BW]`.
- `i_ready`  in  1  consumer accepts `o_acc_bias`.
- `o_acc_bias`  out  AB_BW*COLS*COLS  result grid, same index packing with AB_BW per element.
- `o_valid`  out  1  `o_acc_bias` is final and stable.
- `o_busy`  out  1  high in ACCUM and OUT.
- `o_done`  out  1  one-cycle pulse on the output handshake.

## Operation
- States: IDLE, ACCUM, OUT.
- IDLE + `i_start`:
  - Latch `i_bias` and `i_num_tiles`; a value of 0 is treated as 1.
  - Clear the tile counter and go to ACCUM.
  - `i_psum_valid` in the same cycle is ignored.
- ACCUM, each cycle with `i_psum_valid=1`:
  - First tile: acc[k] = sat(bias[c] + psum[k]).
  - Later tiles: acc[k] = sat(acc[k] + psum[k]).
  - Counter increments by 1.
  - When the accepted tile is tile number num_tiles, go to OUT.
- ACCUM with `i_psum_valid=0`: hold state, accumulators and counter.
- OUT:
  - `o_valid=1`; `o_acc_bias` holds the accumulators unchanged.
  - On `o_valid & i_ready`: pulse `o_done`, go to IDLE.
  - `o_acc_bias` keeps its last value in IDLE until the next job's first tile.
- Ignored inputs:
  - `i_start` outside IDLE, with no effect on the job.
  - `i_psum_valid` in IDLE or OUT, with data dropped.
- Arithmetic:
  - psum and bias are sign-extended to AB_BW+1 bits before each add.
  - The result is clamped to [-2^(AB_BW-1), 2^(AB_BW-1)-1], saturating at every step.
  - No wrap-around ever appears on the output.
- Bias indexing: element (r,c) always uses bias column c.

## Timing
- Reset values: state IDLE; `o_acc_bias` 0, `o_valid` 0, `o_busy` 0, `o_done` 0; counter and latched bias 0.
- Reset asserted mid-job aborts immediately; after release the block is in IDLE and needs a new `i_start`.
- `o_busy` rises the cycle after `i_start` is accepted.
- `o_valid` rises the cycle after the last tile is accepted.
- Latency from `i_start` to `o_valid`, with psum valid every cycle starting the cycle after start: num_tiles+1 cycles.
- `o_done` is high the cycle after the handshake, coincident with the return to IDLE; `o_valid` and `o_busy` are 0 in that cycle.
- The earliest next `i_start` is accepted in the `o_done` cycle.
- `i_ready` is a don't-care outside OUT.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset then single job, COLS=5, `i_num_tiles=1`, all psum=100, all bias=-30, `i_ready=1` -> `o_valid` one cycle after the tile, every element 70, `o_done` pulses once.
- `i_num_tiles=4`, psum element k = k+1 each tile, bias[c]=c, psum valid gapped every other cycle -> element k = 4(k+1)+c, `o_valid` exactly one cycle after the 4th valid.
- Positive saturation: 40 tiles of psum=+524287 (PSUM_BW max) -> every element 16777215 and holds there; mirror with -524288 -> -16777216.
- Backpressure: `i_ready=0` for 10 cycles in OUT with `i_psum_valid` and `i_start` toggling -> `o_acc_bias` stable, no extra accumulation, job not restarted; `i_ready=1` -> `o_done` next cycle.
- `i_num_tiles=0` -> behaves as 1 tile; `i_start` during ACCUM -> ignored, count unchanged.
- `rst_n` pulsed low mid-ACCUM (async, between edges) -> outputs 0 immediately; a following job of 2 tiles of 5, bias 0 -> all elements 10, with no residue from the aborted job.

Source files
------------

// File: rtl/acc_bias_accum_if.sv
// Handshake/data bundle between the PE-array tile source, acc_bias_accum and the
// bound/ReLU consumer. The master drives the job/tile inputs; the slave is the accumulator.
interface acc_bias_accum_if #(
  parameter int COLS    = 5,
  parameter int PSUM_BW = 20,
  parameter int BIAS_BW = 16,
  parameter int AB_BW   = 25,
  parameter int CNT_BW  = 8
) ();
  logic                          i_start;
  logic [CNT_BW-1:0]             i_num_tiles;
  logic [BIAS_BW*COLS-1:0]       i_bias;
  logic                          i_psum_valid;
  logic [PSUM_BW*COLS*COLS-1:0]  i_psum;
  logic                          i_ready;
  logic [AB_BW*COLS*COLS-1:0]    o_acc_bias;
  logic                          o_valid;
  logic                          o_busy;
  logic                          o_done;

  modport master (
    output i_start, i_num_tiles, i_bias, i_psum_valid, i_psum, i_ready,
    input  o_acc_bias, o_valid, o_busy, o_done
  );

  modport slave (
    input  i_start, i_num_tiles, i_bias, i_psum_valid, i_psum, i_ready,
    output o_acc_bias, o_valid, o_busy, o_done
  );
endinterface

// File: rtl/acc_bias_accum.sv
// Accumulates K-dimension psum tiles onto a per-column bias with saturating adds and
// holds the finished COLSxCOLS grid on a ready/valid output until the consumer accepts it.
module acc_bias_accum #(
  parameter int COLS    = 5,
  parameter int PSUM_BW = 20,
  parameter int BIAS_BW = 16,
  parameter int AB_BW   = 25,
  parameter int CNT_BW  = 8
) (
  input logic              clk,
  input logic              rst_n,
  acc_bias_accum_if.slave  bus
);
  localparam int NE = COLS * COLS;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_t;

  state_t                  r_state;
  logic [CNT_BW-1:0]       r_cnt;
  logic [CNT_BW-1:0]       r_num;
  logic [BIAS_BW*COLS-1:0] r_bias;
  logic [AB_BW*NE-1:0]     r_acc;
  logic                    r_valid;
  logic                    r_busy;
  logic                    r_done;

  logic [AB_BW*NE-1:0]     w_acc_next;
  logic [CNT_BW:0]         w_cnt_inc;
  logic                    w_last;
  logic                    w_first;
  logic [BIAS_BW-1:0]      w_b;
  logic [PSUM_BW-1:0]      w_p;
  logic [AB_BW-1:0]        w_a;
  logic [AB_BW:0]          w_base;
  logic [AB_BW:0]          w_add;
  logic [AB_BW:0]          w_sum;

  assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_BW{1'b0}}, 1'b1};
  assign w_last    = (w_cnt_inc == {1'b0, r_num});
  assign w_first   = (r_cnt == '0);

  // One extra headroom bit makes overflow visible as a mismatch of the top two bits.
  always_comb begin
    w_acc_next = r_acc;
    w_b        = '0;
    w_p        = '0;
    w_a        = '0;
    w_base     = '0;
    w_add      = '0;
    w_sum      = '0;
    for (int unsigned k = 0; k < NE; k++) begin
      w_b   = r_bias[(k % COLS)*BIAS_BW +: BIAS_BW];
      w_p   = bus.i_psum[k*PSUM_BW +: PSUM_BW];
      w_a   = r_acc[k*AB_BW +: AB_BW];
      w_add = {{(AB_BW+1-PSUM_BW){w_p[PSUM_BW-1]}}, w_p};
      if (w_first)
        w_base = {{(AB_BW+1-BIAS_BW){w_b[BIAS_BW-1]}}, w_b};
      else
        w_base = {w_a[AB_BW-1], w_a};
      w_sum = w_base + w_add;
      if (w_sum[AB_BW] != w_sum[AB_BW-1])
        w_acc_next[k*AB_BW +: AB_BW] = w_sum[AB_BW] ? {1'b1, {(AB_BW-1){1'b0}}}
                                                    : {1'b0, {(AB_BW-1){1'b1}}};
      else
        w_acc_next[k*AB_BW +: AB_BW] = w_sum[AB_BW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_num   <= '0;
      r_bias  <= '0;
      r_acc   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_num   <= (bus.i_num_tiles == '0) ? {{(CNT_BW-1){1'b0}}, 1'b1} : bus.i_num_tiles;
            r_bias  <= bus.i_bias;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (bus.i_psum_valid) begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_inc[CNT_BW-1:0];
            if (w_last) begin
              r_valid <= 1'b1;
              r_state <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (bus.i_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_acc_bias = r_acc;
  assign bus.o_valid    = r_valid;
  assign bus.o_busy     = r_busy;
  assign bus.o_done     = r_done;
endmodule

// File: tb/tb_acc_bias_accum.sv
// Scenario bench for acc_bias_accum: integer reference model feeds a scoreboard of
// expected grids, each scenario task compares DUT outputs inline.
module tb_acc_bias_accum;
  localparam int COLS    = 5;
  localparam int PSUM_BW = 20;
  localparam int BIAS_BW = 16;
  localparam int AB_BW   = 25;
  localparam int CNT_BW  = 8;
  localparam int NE      = COLS * COLS;
  localparam longint AMAX = (longint'(1) <<< (AB_BW-1)) - 1;
  localparam longint AMIN = -AMAX - 1;

  typedef logic [AB_BW*NE-1:0] grid_t;

  logic clk;
  logic rst_n;

  acc_bias_accum_if #(.COLS(COLS), .PSUM_BW(PSUM_BW), .BIAS_BW(BIAS_BW),
                      .AB_BW(AB_BW), .CNT_BW(CNT_BW)) bus ();

  acc_bias_accum #(.COLS(COLS), .PSUM_BW(PSUM_BW), .BIAS_BW(BIAS_BW),
                   .AB_BW(AB_BW), .CNT_BW(CNT_BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  grid_t  sb[$];
  longint m_acc[NE];
  longint m_bias[COLS];
  int     tb_psum[NE];
  int     tb_bias[COLS];
  int     n_pass  = 0;
  int     n_total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic grid_t model_grid();
    grid_t g;
    longint v;
    for (int k = 0; k < NE; k++) begin
      v = m_acc[k];
      g[k*AB_BW +: AB_BW] = v[AB_BW-1:0];
    end
    return g;
  endfunction

  function automatic longint elem(input int k);
    logic signed [AB_BW-1:0] e;
    e = bus.o_acc_bias[k*AB_BW +: AB_BW];
    return longint'(e);
  endfunction

  task automatic start_job(input int n);
    @(negedge clk);
    bus.i_start     = 1'b1;
    bus.i_num_tiles = n[CNT_BW-1:0];
    for (int c = 0; c < COLS; c++) begin
      bus.i_bias[c*BIAS_BW +: BIAS_BW] = tb_bias[c][BIAS_BW-1:0];
      m_bias[c] = tb_bias[c];
    end
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic send_tile(input bit first);
    longint v;
    for (int k = 0; k < NE; k++) begin
      bus.i_psum[k*PSUM_BW +: PSUM_BW] = tb_psum[k][PSUM_BW-1:0];
      v = (first ? m_bias[k % COLS] : m_acc[k]) + tb_psum[k];
      if (v > AMAX) v = AMAX;
      if (v < AMIN) v = AMIN;
      m_acc[k] = v;
    end
    bus.i_psum_valid = 1'b1;
    @(negedge clk);
    bus.i_psum_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_start = 1'b0; bus.i_num_tiles = '0; bus.i_bias = '0;
    bus.i_psum_valid = 1'b0; bus.i_psum = '0; bus.i_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (bus.o_valid !== 1'b0) $display("FAIL reset_valid got=%0b want=0", bus.o_valid); else n_pass++;
    n_total++; if (bus.o_busy !== 1'b0) $display("FAIL reset_busy got=%0b want=0", bus.o_busy); else n_pass++;
    n_total++; if (bus.o_done !== 1'b0) $display("FAIL reset_done got=%0b want=0", bus.o_done); else n_pass++;
    n_total++; if (bus.o_acc_bias !== '0) $display("FAIL reset_acc got=%h want=0", bus.o_acc_bias); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (bus.o_busy !== 1'b0) $display("FAIL idle_busy got=%0b want=0", bus.o_busy); else n_pass++;
  endtask

  task automatic test_single();
    grid_t g;
    for (int c = 0; c < COLS; c++) tb_bias[c] = -30;
    for (int k = 0; k < NE; k++) tb_psum[k] = 100;
    bus.i_ready = 1'b1;
    start_job(1);
    n_total++; if (bus.o_busy !== 1'b1) $display("FAIL single_busy got=%0b want=1", bus.o_busy); else n_pass++;
    send_tile(1'b1);
    sb.push_back(model_grid());
    n_total++; if (bus.o_valid !== 1'b1) $display("FAIL single_valid got=%0b want=1", bus.o_valid); else n_pass++;
    g = sb.pop_front();
    n_total++; if (bus.o_acc_bias !== g) $display("FAIL single_grid got=%h want=%h", bus.o_acc_bias, g); else n_pass++;
    n_total++; if (elem(12) !== 64'sd70) $display("FAIL single_elem got=%0d want=70", elem(12)); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.o_done !== 1'b1) $display("FAIL single_done got=%0b want=1", bus.o_done); else n_pass++;
    n_total++; if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0)
      $display("FAIL single_after got=valid%0b/busy%0b want=0/0", bus.o_valid, bus.o_busy); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.o_done !== 1'b0) $display("FAIL single_done_pulse got=%0b want=0", bus.o_done); else n_pass++;
  endtask

  task automatic test_gapped();
    grid_t g;
    for (int c = 0; c < COLS; c++) tb_bias[c] = c;
    for (int k = 0; k < NE; k++) tb_psum[k] = k + 1;
    bus.i_ready = 1'b1;
    start_job(4);
    for (int t = 0; t < 4; t++) begin
      if (t == 3) begin
        n_total++; if (bus.o_valid !== 1'b0) $display("FAIL gapped_early_valid got=%0b want=0", bus.o_valid); else n_pass++;
      end
      send_tile(t == 0);
      if (t < 3) @(negedge clk);
    end
    sb.push_back(model_grid());
    n_total++; if (bus.o_valid !== 1'b1) $display("FAIL gapped_valid got=%0b want=1", bus.o_valid); else n_pass++;
    g = sb.pop_front();
    n_total++; if (bus.o_acc_bias !== g) $display("FAIL gapped_grid got=%h want=%h", bus.o_acc_bias, g); else n_pass++;
    n_total++; if (elem(24) !== 64'sd104) $display("FAIL gapped_elem24 got=%0d want=104", elem(24)); else n_pass++;
    n_total++; if (elem(7) !== 64'sd34) $display("FAIL gapped_elem7 got=%0d want=34", elem(7)); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.o_done !== 1'b1) $display("FAIL gapped_done got=%0b want=1", bus.o_done); else n_pass++;
  endtask

  task automatic test_saturation();
    grid_t g;
    longint lim;
    for (int s = 0; s < 2; s++) begin
      lim = (s == 0) ? AMAX : AMIN;
      for (int c = 0; c < COLS; c++) tb_bias[c] = (s == 0) ? 32767 : -32768;
      for (int k = 0; k < NE; k++) tb_psum[k] = (s == 0) ? 524287 : -524288;
      bus.i_ready = 1'b1;
      start_job(40);
      for (int t = 0; t < 40; t++) send_tile(t == 0);
      sb.push_back(model_grid());
      n_total++; if (bus.o_valid !== 1'b1) $display("FAIL sat%0d_valid got=%0b want=1", s, bus.o_valid); else n_pass++;
      g = sb.pop_front();
      n_total++; if (bus.o_acc_bias !== g) $display("FAIL sat%0d_grid got=%h want=%h", s, bus.o_acc_bias, g); else n_pass++;
      n_total++; if (elem(s * 9) !== lim) $display("FAIL sat%0d_elem got=%0d want=%0d", s, elem(s * 9), lim); else n_pass++;
      @(negedge clk);
      n_total++; if (bus.o_done !== 1'b1) $display("FAIL sat%0d_done got=%0b want=1", s, bus.o_done); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    grid_t g;
    for (int c = 0; c < COLS; c++) tb_bias[c] = int'($urandom_range(0, 65535)) - 32768;
    bus.i_ready = 1'b0;
    start_job(2);
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < NE; k++) tb_psum[k] = int'($urandom_range(0, 1048575)) - 524288;
      send_tile(t == 0);
    end
    sb.push_back(model_grid());
    for (int i = 0; i < 10; i++) begin
      n_total++; if (bus.o_valid !== 1'b1 || bus.o_acc_bias !== sb[0])
        $display("FAIL bp_hold%0d got=valid%0b/%h want=valid1/%h", i, bus.o_valid, bus.o_acc_bias, sb[0]); else n_pass++;
      bus.i_psum_valid = i[0];
      bus.i_start      = ~i[0];
      bus.i_num_tiles  = 8'd1;
      for (int k = 0; k < NE; k++) bus.i_psum[k*PSUM_BW +: PSUM_BW] = PSUM_BW'($urandom);
      @(negedge clk);
    end
    bus.i_psum_valid = 1'b0;
    bus.i_start      = 1'b0;
    bus.i_ready      = 1'b1;
    @(negedge clk);
    n_total++; if (bus.o_done !== 1'b1) $display("FAIL bp_done got=%0b want=1", bus.o_done); else n_pass++;
    g = sb.pop_front();
    n_total++; if (bus.o_acc_bias !== g) $display("FAIL bp_grid got=%h want=%h", bus.o_acc_bias, g); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.o_busy !== 1'b0) $display("FAIL bp_no_restart got=%0b want=0", bus.o_busy); else n_pass++;
  endtask

  task automatic test_zero_tiles();
    grid_t g;
    for (int c = 0; c < COLS; c++) tb_bias[c] = 1000 * (c + 1);
    for (int k = 0; k < NE; k++) tb_psum[k] = int'($urandom_range(0, 2000)) - 1000;
    bus.i_ready = 1'b1;
    start_job(0);
    send_tile(1'b1);
    sb.push_back(model_grid());
    n_total++; if (bus.o_valid !== 1'b1) $display("FAIL zero_valid got=%0b want=1", bus.o_valid); else n_pass++;
    g = sb.pop_front();
    n_total++; if (bus.o_acc_bias !== g) $display("FAIL zero_grid got=%h want=%h", bus.o_acc_bias, g); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.o_done !== 1'b1) $display("FAIL zero_done got=%0b want=1", bus.o_done); else n_pass++;
  endtask

  task automatic test_start_in_accum();
    grid_t g;
    for (int c = 0; c < COLS; c++) tb_bias[c] = -7 * c;
    for (int k = 0; k < NE; k++) tb_psum[k] = 3 * k - 20;
    bus.i_ready = 1'b1;
    start_job(3);
    send_tile(1'b1);
    bus.i_start     = 1'b1;
    bus.i_num_tiles = 8'd1;
    bus.i_bias      = '1;
    @(negedge clk);
    bus.i_start = 1'b0;
    send_tile(1'b0);
    n_total++; if (bus.o_valid !== 1'b0) $display("FAIL restart_early_valid got=%0b want=0", bus.o_valid); else n_pass++;
    send_tile(1'b0);
    sb.push_back(model_grid());
    n_total++; if (bus.o_valid !== 1'b1) $display("FAIL restart_valid got=%0b want=1", bus.o_valid); else n_pass++;
    g = sb.pop_front();
    n_total++; if (bus.o_acc_bias !== g) $display("FAIL restart_grid got=%h want=%h", bus.o_acc_bias, g); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.o_done !== 1'b1) $display("FAIL restart_done got=%0b want=1", bus.o_done); else n_pass++;
  endtask

  task automatic test_reset_mid_job();
    grid_t g;
    for (int c = 0; c < COLS; c++) tb_bias[c] = 50;
    for (int k = 0; k < NE; k++) tb_psum[k] = 7;
    bus.i_ready = 1'b1;
    start_job(3);
    send_tile(1'b1);
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0)
      $display("FAIL midrst_flags got=busy%0b/valid%0b want=0/0", bus.o_busy, bus.o_valid); else n_pass++;
    n_total++; if (bus.o_acc_bias !== '0) $display("FAIL midrst_acc got=%h want=0", bus.o_acc_bias); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (bus.o_busy !== 1'b0) $display("FAIL midrst_idle got=%0b want=0", bus.o_busy); else n_pass++;
    for (int c = 0; c < COLS; c++) tb_bias[c] = 0;
    for (int k = 0; k < NE; k++) tb_psum[k] = 5;
    start_job(2);
    send_tile(1'b1);
    send_tile(1'b0);
    sb.push_back(model_grid());
    n_total++; if (bus.o_valid !== 1'b1) $display("FAIL midrst_valid got=%0b want=1", bus.o_valid); else n_pass++;
    g = sb.pop_front();
    n_total++; if (bus.o_acc_bias !== g) $display("FAIL midrst_grid got=%h want=%h", bus.o_acc_bias, g); else n_pass++;
    n_total++; if (elem(18) !== 64'sd10) $display("FAIL midrst_elem got=%0d want=10", elem(18)); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.o_done !== 1'b1) $display("FAIL midrst_done got=%0b want=1", bus.o_done); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_gapped();
    test_saturation();
    test_backpressure();
    test_zero_tiles();
    test_start_in_accum();
    test_reset_mid_job();
    n_total++; if (sb.size() != 0) $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
